sim_run_controller: RTL and testbench
=====================================

SIM_RUN_CONTROLLER -- requirements
Module: sim_run_controller

Interface
REQ-001 Parameters SHALL be: PC_W, default 32, PC width; DATA_W, default 32, instruction/ALU result width; RESET_CYCLES, default 2, CPU reset hold length (>=1); MAX_CYCLES, default 25, run cycle budget (>=1); HALT_REPEAT, default 3, identical-PC run that signals a halt (>=2); DEPTH, default 16, trace FIFO entries (power of 2, >=2).
REQ-002 Port clk, input, 1: single clock; all logic SHALL be rising-edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port cpu_reset, output, 1: reset driven to the processor under test.
REQ-005 Port pc, input, PC_W: processor program counter.
REQ-006 Port instruction, input, DATA_W: current instruction.
REQ-007 Port alu_result, input, DATA_W: current ALU result.
REQ-008 Port zero, input, 1: ALU zero flag.
REQ-009 Port rd_valid, output, 1: trace FIFO holds an entry.
REQ-010 Port rd_ready, input, 1: consumer accepts the head entry.
REQ-011 Port rd_data, output, PC_W+2*DATA_W+1: head entry, {pc, instruction, alu_result, zero}.
REQ-012 Port cycle_count, output, 32: RUN cycles elapsed.
REQ-013 Port done, output, 1: run finished.
REQ-014 Port halt_reason, output, 2: 00 none, 01 budget exhausted, 10 PC stalled.
REQ-015 Port overflow, output, 1: sticky flag, trace entry dropped.

Function
REQ-016 FSM states SHALL be HOLD, RUN and DONE; HOLD is entered on reset.
REQ-017 HOLD: cpu_reset=1; internal counter increments each cycle; after RESET_CYCLES cycles in HOLD the FSM SHALL move to RUN.
REQ-018 RUN: cpu_reset=0; each cycle cycle_count SHALL increment by 1 and a push of {pc, instruction, alu_result, zero} sampled that cycle SHALL occur.
REQ-019 Push with FIFO full, and no pop in the same cycle: entry dropped, overflow set to 1 and held until reset.
REQ-020 Simultaneous push and pop with FIFO full: both SHALL succeed; no overflow.
REQ-021 Pop SHALL occur when rd_valid && rd_ready; rd_data SHALL show the head entry combinationally from storage; pointers wrap modulo DEPTH; occupancy counter ranges 0..DEPTH.
REQ-022 PC-stall detector: in RUN a repeat counter SHALL increment when pc equals the pc registered the previous RUN cycle, else clear to 1; the first RUN cycle loads 1.
REQ-023 RUN->DONE when the repeat counter reaches HALT_REPEAT (halt_reason=10) or cycle_count reaches MAX_CYCLES (halt_reason=01), evaluated after the cycle's update; if both occur together, halt_reason SHALL be 10.
REQ-024 DONE: done=1, no pushes, cycle_count frozen, cpu_reset=1, pops continue until FIFO empty; DONE SHALL be left only by reset.
REQ-025 cycle_count SHALL saturate at 2^32-1.

Reset
REQ-026 On reset assertion, asynchronously: state=HOLD, cpu_reset=1, cycle_count=0, done=0, halt_reason=00, overflow=0, FIFO empty (rd_valid=0), rd_data=0, repeat counter=0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL discard all trace contents and restart the HOLD sequence after deassertion.

Verification
REQ-028 Defaults, pc incrementing by 4 from 0, rd_ready=1 -> cpu_reset high 2 cycles after reset release; done=1, halt_reason=01, cycle_count=25; 25 entries popped in order, pc 0..0x60.
REQ-029 pc sequence 0,4,8,8,8 -> done on the 5th RUN cycle, halt_reason=10, cycle_count=5.
REQ-030 rd_ready=0, DEPTH=16, budget 25 -> rd_valid=1, overflow=1 after 17th push, first 16 entries preserved, entries 17..25 dropped.
REQ-031 FIFO full, rd_ready raised same cycle as a push -> one pop and one push, occupancy stays 16, overflow stays 0.
REQ-032 Reset pulsed at cycle 10 of RUN -> all outputs return to REQ-026 values asynchronously; new run restarts from HOLD with cycle_count=0.
REQ-033 pc stalled at cycle 25 with HALT_REPEAT reached simultaneously -> halt_reason=10.

Source files
------------

// File: rtl/sim_run_controller_if.sv
// sim_run_controller_if: trace read stream (rd_valid/rd_ready/rd_data); master = controller, slave = consumer
interface sim_run_controller_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);
  logic                       rd_valid;
  logic                       rd_ready;
  logic [PC_W+2*DATA_W:0]     rd_data;
  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/sim_run_controller.sv
// sim_run_controller: holds CPU in reset, runs it under a cycle budget / PC-stall watchdog, traces {pc,instruction,alu_result,zero} into a FIFO; ports clk, reset, cpu_reset, pc, instruction, alu_result, zero, rd (trace stream), cycle_count, done, halt_reason, overflow
module sim_run_controller #(
  parameter int PC_W         = 32,
  parameter int DATA_W       = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 25,
  parameter int HALT_REPEAT  = 3,
  parameter int DEPTH        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  cpu_reset,
  input  logic [PC_W-1:0]       pc,
  input  logic [DATA_W-1:0]     instruction,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  zero,
  sim_run_controller_if.master  rd,
  output logic [31:0]           cycle_count,
  output logic                  done,
  output logic [1:0]            halt_reason,
  output logic                  overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = PC_W + 2*DATA_W + 1;
  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] hcnt, hcnt_nx, rep, rep_nx, cnt_nx;
  logic [1:0] reason_nx;
  logic [PC_W-1:0] pc_q;
  logic run, hold, stall, budget;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] occ;
  logic pop, full, wr;
  assign run = state == RUN;
  assign hold = state == HOLD;
  assign cpu_reset = !run;
  assign done = state == DONE;
  always_comb begin
    hcnt_nx = hold ? hcnt + 32'd1 : hcnt;
    cnt_nx = run && cycle_count != '1 ? cycle_count + 32'd1 : cycle_count;
    // rep==0 marks the first RUN cycle, which has no previous pc to compare against
    rep_nx = run ? (rep != 0 && pc == pc_q ? rep + 32'd1 : 32'd1) : rep;
    stall = run && rep_nx == 32'(HALT_REPEAT);
    budget = run && cnt_nx == 32'(MAX_CYCLES);
    state_nx = hold && hcnt == 32'(RESET_CYCLES - 1) ? RUN : (stall || budget) ? DONE : state;
    reason_nx = stall ? 2'b10 : budget ? 2'b01 : halt_reason;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HOLD;
      hcnt <= '0;
      rep <= '0;
      pc_q <= '0;
      cycle_count <= '0;
      halt_reason <= '0;
    end else begin
      state <= state_nx;
      hcnt <= hcnt_nx;
      rep <= rep_nx;
      pc_q <= run ? pc : pc_q;
      cycle_count <= cnt_nx;
      halt_reason <= reason_nx;
    end
  end
  assign pop = rd.rd_valid && rd.rd_ready;
  assign full = occ == (AW+1)'(DEPTH);
  // a pop frees the slot this same cycle, so a full FIFO still accepts the push
  assign wr = run && (!full || pop);
  assign rd.rd_valid = occ != '0;
  assign rd.rd_data = rd.rd_valid ? mem[rp] : '0;
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= {pc, instruction, alu_result, zero};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
      overflow <= 1'b0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      occ <= occ + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      overflow <= overflow || (run && full && !pop);
    end
  end
endmodule

// File: tb/tb_sim_run_controller.sv
// tb_sim_run_controller: directed-vector bench for sim_run_controller at default parameters
module tb_sim_run_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_reset, zero, done, overflow;
  logic [31:0] pc, instruction, alu_result, cycle_count;
  logic [1:0] halt_reason;
  int vectors = 0;
  int errs = 0;
  sim_run_controller_if #(.PC_W(32), .DATA_W(32)) rd_if ();
  sim_run_controller dut (
    .clk(clk), .reset(reset), .cpu_reset(cpu_reset), .pc(pc),
    .instruction(instruction), .alu_result(alu_result), .zero(zero),
    .rd(rd_if), .cycle_count(cycle_count), .done(done),
    .halt_reason(halt_reason), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [96:0] ent(input logic [31:0] p, input int k);
    logic [31:0] kk;
    kk = k;
    return {p, 32'h1000_0000 + kk, 32'hA000_0000 ^ kk, kk[0]};
  endfunction
  task automatic drive(input logic [31:0] p, input int k);
    logic [31:0] kk;
    kk = k;
    pc = p;
    instruction = 32'h1000_0000 + kk;
    alu_result = 32'hA000_0000 ^ kk;
    zero = kk[0];
  endtask
  task automatic start_run(input logic rdy);
    reset = 1'b1;
    rd_if.rd_ready = rdy;
    drive(0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("hold_cpu_reset", cpu_reset, 1);
    tick();
    chk("run_cpu_reset", cpu_reset, 0);
    chk("run_start_count", cycle_count, 0);
  endtask
  task automatic chk_reset_vals();
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_count", cycle_count, 0);
    chk("rst_done", done, 0);
    chk("rst_reason", halt_reason, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_valid", rd_if.rd_valid, 0);
    chk("rst_data", rd_if.rd_data, 0);
  endtask
  initial begin
    rd_if.rd_ready = 1'b1;
    drive(0, 0);
    tick();
    chk_reset_vals();
    // budget run, consumer always ready: each entry is visible the cycle after its push
    start_run(1'b1);
    for (int k = 0; k < 25; k++) begin
      drive(32'(4*k), k);
      tick();
      chk("bud_count", cycle_count, 32'(k+1));
      chk("bud_data", rd_if.rd_data, ent(32'(4*k), k));
      chk("bud_done", done, k == 24);
    end
    chk("bud_reason", halt_reason, 2'b01);
    chk("bud_cpu_reset", cpu_reset, 1);
    tick();
    chk("bud_drained", rd_if.rd_valid, 0);
    tick();
    tick();
    chk("done_sticky", done, 1);
    chk("done_frozen", cycle_count, 25);
    // asynchronous reset in the middle of a run
    start_run(1'b1);
    for (int k = 0; k < 10; k++) begin
      drive(32'(4*k), k);
      tick();
    end
    chk("mid_count", cycle_count, 10);
    reset = 1'b1;
    #2;
    chk_reset_vals();
    // PC stall 0,4,8,8,8
    start_run(1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(k < 2 ? 32'(4*k) : 32'd8, k);
      tick();
      chk("stall_done", done, k == 4);
    end
    chk("stall_reason", halt_reason, 2'b10);
    chk("stall_count", cycle_count, 5);
    // overflow with no consumer
    start_run(1'b0);
    for (int k = 0; k < 25; k++) begin
      drive(32'(4*k), k);
      tick();
      chk("ovf_flag", overflow, k >= 16);
      chk("ovf_valid", rd_if.rd_valid, 1);
    end
    chk("ovf_reason", halt_reason, 2'b01);
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_data", rd_if.rd_data, ent(32'(4*i), i));
      tick();
    end
    chk("ovf_empty", rd_if.rd_valid, 0);
    // full FIFO with simultaneous pop and push
    start_run(1'b0);
    for (int k = 0; k < 16; k++) begin
      drive(32'(4*k), k);
      tick();
    end
    chk("full_no_ovf", overflow, 0);
    chk("full_head", rd_if.rd_data, ent(0, 0));
    rd_if.rd_ready = 1'b1;
    drive(32'd64, 16);
    tick();
    chk("pp_no_ovf", overflow, 0);
    chk("pp_head", rd_if.rd_data, ent(32'd4, 1));
    rd_if.rd_ready = 1'b0;
    drive(32'd68, 17);
    tick();
    chk("pp_still_full", overflow, 1);
    for (int k = 18; k < 25; k++) begin
      drive(32'(4*k), k);
      tick();
    end
    rd_if.rd_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      chk("pp_data", rd_if.rd_data, ent(32'(4*i), i));
      tick();
    end
    chk("pp_empty", rd_if.rd_valid, 0);
    // stall limit and budget reached on the same cycle
    start_run(1'b1);
    for (int k = 0; k < 25; k++) begin
      drive(k <= 22 ? 32'(4*k) : 32'd88, k);
      tick();
      chk("both_done", done, k == 24);
    end
    chk("both_reason", halt_reason, 2'b10);
    chk("both_count", cycle_count, 25);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
